// File: rtl/sync_sub_recover.sv
// Digit-serial subtractor recovering b = y - a from an adder's (DATA_WIDTH+1)-bit sum.
// The result comes out over a valid/ready pair; err marks a difference that does not fit in DATA_WIDTH bits.
module sync_sub_recover #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   y,
  input  logic [DATA_WIDTH-1:0] a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  err,
  output logic [1:0]            o_dbg_state
);

  localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if ((DIGIT_WIDTH <= 0) || ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_bad_width
    $error("sync_sub_recover: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake semantics: a transfer happens on a rising edge where valid and
  // ready are both high; valid holds its payload until that edge, and ready
  // is decoded only from registered state (never from valid).
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_borrow;
  logic [DATA_WIDTH:0]     r_y;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_last;
  logic [DIGIT_WIDTH-1:0]  w_y_dig;
  logic [DIGIT_WIDTH-1:0]  w_a_dig;
  logic [DIGIT_WIDTH:0]    w_diff;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = (r_state == S_DONE);
  assign b           = r_b;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_y_dig  = r_y[int'(r_cnt) * DIGIT_WIDTH +: DIGIT_WIDTH];
  assign w_a_dig  = r_a[int'(r_cnt) * DIGIT_WIDTH +: DIGIT_WIDTH];
  // Top bit of the widened difference is the borrow out of this digit.
  assign w_diff   = {1'b0, w_y_dig} - {1'b0, w_a_dig} - {{DIGIT_WIDTH{1'b0}}, r_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_y      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_err    <= 1'b0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_y      <= y;
      r_a      <= a;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_b[int'(r_cnt) * DIGIT_WIDTH +: DIGIT_WIDTH] <= w_diff[DIGIT_WIDTH-1:0];
      r_borrow <= w_diff[DIGIT_WIDTH];
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      // Out of range when the sum's carry bit and the final borrow disagree.
      if (w_last) r_err <= r_y[DATA_WIDTH] ^ w_diff[DIGIT_WIDTH];
    end
  end

endmodule

// File: tb/tb_sync_sub_recover.sv
// Directed and adder-loopback bench for sync_sub_recover at default parameters.
module tb_sync_sub_recover;

  localparam int DW = 32;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   y;
  logic [DW-1:0] a;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] b;
  logic          err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q[$];

  sync_sub_recover #(.DATA_WIDTH(DW), .DIGIT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y           (y),
    .a           (a),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .b           (b),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all entered and left on a falling edge
  task automatic wait_ready(input string tag);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic send(input string tag, input logic [DW:0] yv, input logic [DW-1:0] av);
    in_valid = 1'b1;
    y        = yv;
    a        = av;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_rdy_drop"}, 64'(in_ready), 64'd0);
  endtask

  // scoreboard: waits for out_valid, compares against the head of exp_q
  task automatic collect(input string tag);
    int lat = 0;
    logic [DW:0] e;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_ov"}, 64'(out_valid), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(ND));
    check({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_b"}, 64'(b), 64'(e[DW-1:0]));
    check({tag, "_err"}, 64'(err), 64'(e[DW]));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [DW:0] yv, input logic [DW-1:0] av,
                        input logic [DW-1:0] eb, input logic ee);
    exp_q.push_back({ee, eb});
    out_ready = 1'b1;
    wait_ready(tag);
    send(tag, yv, av);
    collect(tag);
    handshake(tag);
  endtask

  initial begin
    logic [DW-1:0] av, bv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y         = '0;
    a         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // basic and boundary vectors
    run_op("basic",  33'd300,          32'd100, 32'd200,        1'b0);
    run_op("ripple", 33'h1_0000_0000,  32'd1,   32'hFFFF_FFFF,  1'b0);
    run_op("neg",    33'd5,            32'd10,  32'hFFFF_FFFB,  1'b1);
    run_op("over",   33'h1_FFFF_FFFF,  32'd0,   32'hFFFF_FFFF,  1'b1);
    run_op("maxfit", 33'h1_FFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("zero",   33'd0,            32'd0,   32'd0,          1'b0);

    // backpressure with in_valid held and y/a wiggling
    exp_q.push_back({1'b0, 32'd13});
    out_ready = 1'b0;
    wait_ready("bp");
    send("bp", 33'd20, 32'd7);
    collect("bp");
    check("bp_state_done", 64'(dbg_state), 64'd2);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y = {1'b0, 32'($urandom)};
      a = 32'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d_ov", i), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_b", i), 64'(b), 64'd13);
      check($sformatf("bp_hold%0d_err", i), 64'(err), 64'd0);
      check($sformatf("bp_hold%0d_rdy", i), 64'(in_ready), 64'd0);
    end
    y = 33'd50;
    a = 32'd8;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ov", 64'(out_valid), 64'd0);
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 32'd42});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_rdy_drop", 64'(in_ready), 64'd0);
    collect("bp_next");
    handshake("bp_next");

    // reset in BUSY after two digits
    wait_ready("rst_busy");
    send("rst_busy", 33'd1000, 32'd1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_busy_partial_b", 64'(b), 64'h3E7);
    rst = 1'b1;
    #1;
    check("rst_busy_ov", 64'(out_valid), 64'd0);
    check("rst_busy_b", 64'(b), 64'd0);
    check("rst_busy_err", 64'(err), 64'd0);
    check("rst_busy_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset while holding a flagged result in DONE
    exp_q.push_back({1'b1, 32'hFFFF_FFFE});
    out_ready = 1'b0;
    wait_ready("rst_done");
    send("rst_done", 33'd3, 32'd5);
    collect("rst_done");
    #2;
    rst = 1'b1;
    #1;
    check("rst_done_ov", 64'(out_valid), 64'd0);
    check("rst_done_b", 64'(b), 64'd0);
    check("rst_done_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    run_op("after_rst", 33'd70000, 32'd69999, 32'd1, 1'b0);

    // loopback through a behavioural adder
    for (int i = 0; i < 1000; i++) begin
      av = 32'($urandom);
      bv = 32'($urandom_range(0, 32'hFFFF_FFFF));
      run_op($sformatf("loop%0d", i), {1'b0, av} + {1'b0, bv}, av, bv, 1'b0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
